// File: rtl/ps2phy_fifo.sv
`default_nettype none
// ============================================================================
// Module : ps2phy_fifo
// PS/2 device-to-host receiver: input synchronisers, device_clk glitch
// filter, frame FSM with parity/stop/timeout checks, FWFT receive FIFO.
// Optional feature macro: PS2PHY_ERRCNT_EN adds the saturating err_count port.
// Revision: 1.0 - initial release
// ============================================================================
module ps2phy_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic                          device_clk,
    input  logic                          device_dat,
    output logic [7:0]                    sym_data,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          err_parity,
    output logic                          err_frame,
`ifdef PS2PHY_ERRCNT_EN
    output logic [7:0]                    err_count,
`endif
    output logic                          overflow
);

    localparam int c_AW          = $clog2(FIFO_DEPTH);
    localparam int c_TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int c_TW          = $clog2(c_TIMEOUT_CYC + 1);
    localparam int c_FW          = $clog2(FILTER_LEN + 1);

    localparam logic [c_FW-1:0] c_FLT_MAX = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_MAX  = c_TW'(c_TIMEOUT_CYC - 1);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_DATA   = 2'd1;
    localparam logic [1:0] c_S_PARITY = 2'd2;
    localparam logic [1:0] c_S_STOP   = 2'd3;

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_flt, r_clk_flt_d;
    logic [c_FW-1:0] r_flt_cnt;
    logic            w_edge, w_fall;

    logic [1:0]      r_state, w_state_nxt;
    logic            w_shift_en, w_par_en, w_stop_en, w_timeout, w_par_ok;
    logic [c_TW-1:0] r_to_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_par;
    logic            r_push, r_err_parity, r_err_frame, r_overflow;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            w_pop, w_full, w_wr;

    // Bus idles high, so synchronisers and filter reset to 1 to avoid a false start edge.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_clk_flt   <= 1'b1;
            r_clk_flt_d <= 1'b1;
            r_flt_cnt   <= '0;
        end else begin
            r_clk_s1    <= device_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= device_dat;
            r_dat_s2    <= r_dat_s1;
            r_clk_flt_d <= r_clk_flt;
            if (r_clk_s2 == r_clk_flt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_MAX) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_edge    = r_clk_flt ^ r_clk_flt_d;
    assign w_fall    = r_clk_flt_d & ~r_clk_flt;
    assign w_timeout = (r_state != c_S_IDLE) && (r_to_cnt == c_TO_MAX);
    assign w_par_ok  = ^{r_shift, r_par};

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (w_fall && !r_dat_s2) w_state_nxt = c_S_DATA;
            c_S_DATA:   if (w_timeout) w_state_nxt = c_S_IDLE;
                        else if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = c_S_PARITY;
            c_S_PARITY: if (w_timeout) w_state_nxt = c_S_IDLE;
                        else if (w_fall) w_state_nxt = c_S_STOP;
            c_S_STOP:   if (w_timeout || w_fall) w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_stop_en  = 1'b0;
        case (r_state)
            c_S_DATA:   w_shift_en = w_fall & ~w_timeout;
            c_S_PARITY: w_par_en   = w_fall & ~w_timeout;
            c_S_STOP:   w_stop_en  = w_fall & ~w_timeout;
            default:    ;
        endcase
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_to_cnt     <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_par        <= 1'b0;
            r_push       <= 1'b0;
            r_err_parity <= 1'b0;
            r_err_frame  <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE || w_edge || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift   <= {r_dat_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (r_state == c_S_IDLE) begin
                r_bit_cnt <= '0;
            end
            if (w_par_en) begin
                r_par <= r_dat_s2;
            end
            // r_shift stays stable long after the stop edge, so it feeds the FIFO directly.
            r_push       <= w_stop_en & w_par_ok & r_dat_s2;
            r_err_parity <= w_stop_en & ~w_par_ok;
            r_err_frame  <= (w_stop_en & ~r_dat_s2) | w_timeout;
        end
    end

    assign w_pop  = sym_valid & sym_ready;
    assign w_full = (r_level == c_DEPTH);
    assign w_wr   = r_push & (~w_full | w_pop);

    always_ff @(posedge clkin) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_overflow <= r_push & w_full & ~w_pop;
        end
    end

    assign sym_valid  = (r_level != '0);
    assign sym_data   = sym_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign level      = r_level;
    assign err_parity = r_err_parity;
    assign err_frame  = r_err_frame;
    assign overflow   = r_overflow;

`ifdef PS2PHY_ERRCNT_EN
    logic [7:0] r_err_count;
    logic [9:0] w_err_sum;

    assign w_err_sum = {2'b00, r_err_count} + {9'd0, r_err_parity}
                     + {9'd0, r_err_frame} + {9'd0, r_overflow};

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else begin
            r_err_count <= (w_err_sum > 10'd255) ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2phy_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2phy_fifo
// Directed self-checking bench for ps2phy_fifo (FIFO_DEPTH=4, 200-cycle timeout).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2phy_fifo;

    localparam int c_HALF = 20;

    logic       clkin = 1'b0;
    logic       rst   = 1'b1;
    logic       device_clk = 1'b1;
    logic       device_dat = 1'b1;
    logic       sym_ready  = 1'b0;
    logic [7:0] sym_data;
    logic       sym_valid;
    logic [2:0] level;
    logic       err_parity, err_frame, overflow;
`ifdef PS2PHY_ERRCNT_EN
    logic [7:0] err_count;
`endif

    ps2phy_fifo #(
        .CLK_HZ     (1000000),
        .FIFO_DEPTH (4),
        .FILTER_LEN (8),
        .TIMEOUT_US (200)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .device_clk (device_clk),
        .device_dat (device_dat),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .level      (level),
        .err_parity (err_parity),
        .err_frame  (err_frame),
`ifdef PS2PHY_ERRCNT_EN
        .err_count  (err_count),
`endif
        .overflow   (overflow)
    );

    always #5 clkin = ~clkin;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_par = 0;
    int         n_frm = 0;
    int         n_ovf = 0;
    logic [7:0] pop_log [$];

    // Observed-event log, sampled on the falling edge away from the active edge.
    always @(negedge clkin) begin
        if (sym_valid && sym_ready) pop_log.push_back(sym_data);
        if (err_parity) n_par = n_par + 1;
        if (err_frame)  n_frm = n_frm + 1;
        if (overflow)   n_ovf = n_ovf + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pop_at(input int idx);
        if (idx < pop_log.size()) return int'(pop_log[idx]);
        return 32'hDEAD;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic send_bit(input logic b);
        device_dat = b;
        wait_cyc(c_HALF);
        device_clk = 1'b0;
        wait_cyc(c_HALF);
        device_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ par_flip);
        send_bit(stop);
        device_dat = 1'b1;
        wait_cyc(c_HALF + 5);
    endtask

    int b_pop, b_par, b_frm, b_ovf;

    task automatic mark();
        b_pop = pop_log.size();
        b_par = n_par;
        b_frm = n_frm;
        b_ovf = n_ovf;
    endtask

    initial begin
        wait_cyc(4);
        chk("rst_valid", sym_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", sym_data, 0);
        chk("rst_errs", {err_parity, err_frame, overflow}, 0);
        rst = 1'b0;
        wait_cyc(5);

        // Good frame 0x1C, consumer always ready
        sym_ready = 1'b1;
        mark();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("1c_pops", pop_log.size() - b_pop, 1);
        chk("1c_data", pop_at(b_pop), 8'h1C);
        chk("1c_errs", (n_par - b_par) + (n_frm - b_frm), 0);
        chk("1c_level", level, 0);

        // Parity error
        mark();
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_err", n_par - b_par, 1);
        chk("par_pops", pop_log.size() - b_pop, 0);
        chk("par_level", level, 0);

        // Bad stop bit
        mark();
        send_frame(8'h33, 1'b0, 1'b0);
        chk("stop_frm", n_frm - b_frm, 1);
        chk("stop_par", n_par - b_par, 0);
        chk("stop_level", level, 0);

        // Overflow: 5 frames into a 4-deep FIFO with no consumer
        sym_ready = 1'b0;
        mark();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1);
        chk("ovf_level4", level, 4);
        chk("ovf_head", sym_data, 8'h01);
        chk("ovf_none_yet", n_ovf - b_ovf, 0);
        send_frame(8'h05, 1'b0, 1'b1);
        chk("ovf_level_full", level, 4);
        chk("ovf_pulse", n_ovf - b_ovf, 1);
        sym_ready = 1'b1;
        wait_cyc(10);
        chk("ovf_pops", pop_log.size() - b_pop, 4);
        for (int i = 0; i < 4; i++) chk("ovf_order", pop_at(b_pop + i), i + 1);
        chk("ovf_drained", level, 0);

        // Timeout after 4 data bits, then a clean 0xF0
        mark();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        device_dat = 1'b1;
        wait_cyc(300);
        chk("to_frm", n_frm - b_frm, 1);
        chk("to_pops", pop_log.size() - b_pop, 0);
        send_frame(8'hF0, 1'b0, 1'b1);
        chk("to_next_pops", pop_log.size() - b_pop, 1);
        chk("to_next_data", pop_at(b_pop), 8'hF0);
        chk("to_next_frm", n_frm - b_frm, 1);

        // 3-cycle glitch with data low must not look like a start bit
        mark();
        device_dat = 1'b0;
        wait_cyc(5);
        device_clk = 1'b0;
        wait_cyc(3);
        device_clk = 1'b1;
        wait_cyc(5);
        device_dat = 1'b1;
        wait_cyc(40);
        chk("gl_quiet", (pop_log.size() - b_pop) + (n_par - b_par) + (n_frm - b_frm), 0);
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("gl_next_pops", pop_log.size() - b_pop, 1);
        chk("gl_next_data", pop_at(b_pop), 8'hA5);
        chk("gl_next_errs", (n_par - b_par) + (n_frm - b_frm), 0);

        // Reset mid-frame with a byte already queued
        sym_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1);
        chk("mr_level1", level, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", sym_valid, 0);
        chk("mr_level", level, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        sym_ready = 1'b1;
        mark();
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("mr_pops", pop_log.size() - b_pop, 1);
        chk("mr_data", pop_at(b_pop), 8'h5A);
        chk("mr_errs", (n_par - b_par) + (n_frm - b_frm) + (n_ovf - b_ovf), 0);
        chk("mr_level_end", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2phy_fifo.md
PS2PHY_FIFO -- requirements
Module: ps2phy_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000: clkin frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries; must be a power of 2, minimum 2.
REQ-003 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal synchronised samples required before the filtered device_clk level changes.
REQ-004 SHALL have parameter TIMEOUT_US, default 2000: maximum gap between device_clk edges inside a frame, in microseconds.
REQ-005 SHALL have port clkin  input  1: system clock; the block has one clock domain.
REQ-006 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port device_clk  input  1: PS/2 clock line, asynchronous to clkin.
REQ-008 SHALL have port device_dat  input  1: PS/2 data line, asynchronous to clkin.
REQ-009 SHALL have port sym_data  output  8: FIFO head byte.
REQ-010 SHALL have port sym_valid  output  1: FIFO is non-empty.
REQ-011 SHALL have port sym_ready  input  1: consumer accepts the head byte.
REQ-012 SHALL have port level  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 SHALL have port err_parity  output  1: one-cycle pulse when a frame fails the parity check.
REQ-014 SHALL have port err_frame  output  1: one-cycle pulse on a bad stop bit or a timeout.
REQ-015 SHALL have port overflow  output  1: one-cycle pulse when a good byte is dropped.

Function
REQ-016 SHALL pass device_clk and device_dat through 2-flop synchronisers; device_clk then goes through the FILTER_LEN glitch filter.
REQ-017 SHALL sample the synchronised device_dat on each falling edge of the filtered clock.
REQ-018 SHALL implement the frame FSM with these states and transitions:
- IDLE -> DATA on a sampled 0 start bit; a sampled 1 stays in IDLE with no error.
- DATA shifts in 8 bits, LSB first, then -> PARITY.
- PARITY -> STOP.
- STOP -> IDLE.
REQ-019 SHALL accept a frame only when the 8 data bits plus the parity bit contain an odd number of ones; otherwise pulse err_parity and discard the byte.
REQ-020 SHALL, when the stop bit samples 0, pulse err_frame and discard the byte.
REQ-021 SHALL count clkin cycles since the last filtered edge while the FSM is not in IDLE; at TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US it SHALL return to IDLE and pulse err_frame.
REQ-022 SHALL push a good byte into the FIFO in the clkin cycle after the stop-bit falling edge.
REQ-023 SHALL make the FIFO first-word-fall-through:
- sym_data holds the head byte whenever sym_valid=1.
- A pop occurs when sym_valid & sym_ready.
REQ-024 SHALL, on a push while full with no simultaneous pop, drop the new byte, pulse overflow, and leave the FIFO contents unchanged.
REQ-025 SHALL, on a push while full with a simultaneous pop, accept both; level is unchanged and overflow stays 0.
REQ-026 SHALL ignore sym_ready while the FIFO is empty.
REQ-027 SHALL, on a simultaneous push and pop while level=1, leave the new byte at the head the next cycle with sym_valid=1.
REQ-028 SHALL keep level equal to pushes minus pops, with pointers wrapping modulo FIFO_DEPTH.
REQ-029 SHALL give a latency of 1 clkin cycle from push to sym_valid=1 when the FIFO was empty.

Reset
REQ-030 SHALL, while rst=1, asynchronously force: FSM=IDLE, FIFO empty, level=0, sym_valid=0, sym_data=0, all error pulses 0, synchronisers and filter to 1 (idle-high bus), timeout counter 0.
REQ-031 SHALL, when rst is asserted mid-frame, discard the partial frame; the next frame after deassertion SHALL be received normally.

Configuration
REQ-032 SHALL, with `PS2PHY_ERRCNT_EN defined, add output err_count (8 bits): saturating count of err_parity, err_frame and overflow pulses, cleared by rst, holding at 255.
REQ-033 SHALL, without `PS2PHY_ERRCNT_EN, omit the err_count port and its logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) with sym_ready=1 -> sym_valid pulses, sym_data=0x1C, no errors.
REQ-035 SHALL cover: 0x1C sent with parity 1 -> err_parity pulse, level stays 0.
REQ-036 SHALL cover: FIFO_DEPTH=4, sym_ready=0, 5 frames 0x01..0x05 -> level=4, one overflow pulse on the 5th frame, later pops yield 0x01..0x04.
REQ-037 SHALL cover: bus stalled after 4 data bits for more than TIMEOUT_US -> err_frame pulse, FSM in IDLE; the next frame 0xF0 is received correctly.
REQ-038 SHALL cover: 3-cycle glitch on device_clk with FILTER_LEN=8 -> no bit sampled, no output.
REQ-039 SHALL cover: rst pulse mid-frame -> sym_valid=0 and level=0 immediately; the following frame 0x5A is received correctly.
